// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared encodings and default widths for the data memory subsystem
package data_memory_pkg;
   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_BANK_W = 2;
   typedef enum logic {IDLE, STALL} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_HOST} owner_t;
endpackage

// File: rtl/host_wait_counter.sv
// host_wait_counter: saturating count of host denials with a stall-threshold flag
module host_wait_counter #(
   parameter int MAX_WAIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic at_max
);
   localparam int CW = $clog2(MAX_WAIT + 1);
   logic [CW-1:0] cnt;
   // count consecutive denials, saturating so a dropped clear can never wrap
   always_ff @(posedge clk)
      if (!rst_n || clr) cnt <= '0;
      else if (inc && cnt != CW'(MAX_WAIT)) cnt <= cnt + 1'b1;
   assign at_max = cnt == CW'(MAX_WAIT - 1);
endmodule

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: CPU-priority data memory arbiter with starvation-bounded host port
module data_memory_arbiter
   import data_memory_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int BANK_W   = DEF_BANK_W,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_cpu_addr_wr_en,
   input  logic              in_cpu_rd_en,
   input  logic              in_cpu_wr_en,
   input  logic [DATA_W-1:0] in_cpu_bus,
   input  logic [BANK_W-1:0] in_cpu_bank,
   output logic [DATA_W-1:0] out_cpu_rdata,
   output logic              out_cpu_stall,
   input  logic              in_host_req,
   input  logic              in_host_we,
   input  logic [BANK_W-1:0] in_host_bank,
   input  logic [ADDR_W-1:0] in_host_addr,
   input  logic [DATA_W-1:0] in_host_wdata,
   output logic              out_host_gnt,
   output logic [DATA_W-1:0] out_host_rdata,
   output logic              out_host_rvalid,
   output logic [BANK_W-1:0] out_mem_bank,
   output logic [ADDR_W-1:0] out_mem_addr,
   output logic [DATA_W-1:0] out_mem_wdata,
   output logic              out_mem_we,
   output logic              out_mem_re,
   input  logic [DATA_W-1:0] in_mem_rdata
);
   state_t            state_q;
   owner_t            owner_q, owner_d;
   logic [ADDR_W-1:0] cpu_addr_q;
   logic [DATA_W-1:0] cpu_rdata_q, host_rdata_q;
   logic              cpu_act, gnt, deny, at_max;

   // CPU wins in IDLE; the host gets every slot the CPU leaves and the whole STALL slot
   always_comb begin
      cpu_act       = rst_n && state_q == IDLE && (in_cpu_rd_en || in_cpu_wr_en);
      gnt           = rst_n && in_host_req && !cpu_act;
      deny          = rst_n && in_host_req && !gnt;
      out_mem_bank  = cpu_act ? in_cpu_bank : gnt ? in_host_bank : '0;
      out_mem_addr  = cpu_act ? cpu_addr_q : gnt ? in_host_addr : '0;
      out_mem_wdata = cpu_act ? in_cpu_bus : gnt ? in_host_wdata : '0;
      out_mem_we    = cpu_act ? in_cpu_wr_en : gnt && in_host_we;
      out_mem_re    = cpu_act ? !in_cpu_wr_en : gnt && !in_host_we;
      owner_d       = !out_mem_re ? OWN_NONE : cpu_act ? OWN_CPU : OWN_HOST;
   end

   host_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (deny),
      .clr    (!deny),
      .at_max (at_max)
   );

   // STALL lasts exactly one cycle, entered on the denial that hits the threshold
   always_ff @(posedge clk)
      if (!rst_n) state_q <= IDLE;
      else state_q <= (state_q == IDLE && deny && at_max) ? STALL : IDLE;

   // address latch, read-owner tag and held read results
   always_ff @(posedge clk)
      if (!rst_n) begin
         cpu_addr_q   <= '0;
         owner_q      <= OWN_NONE;
         cpu_rdata_q  <= '0;
         host_rdata_q <= '0;
      end else begin
         if (state_q == IDLE && in_cpu_addr_wr_en) cpu_addr_q <= in_cpu_bus[ADDR_W-1:0];
         owner_q <= owner_d;
         if (owner_q == OWN_CPU) cpu_rdata_q <= in_mem_rdata;
         if (owner_q == OWN_HOST) host_rdata_q <= in_mem_rdata;
      end

   assign out_host_gnt    = gnt;
   assign out_cpu_stall   = rst_n && state_q == STALL;
   assign out_host_rvalid = rst_n && owner_q == OWN_HOST;
   assign out_cpu_rdata   = !rst_n ? '0 : owner_q == OWN_CPU ? in_mem_rdata : cpu_rdata_q;
   assign out_host_rdata  = !rst_n ? '0 : owner_q == OWN_HOST ? in_mem_rdata : host_rdata_q;
endmodule
